id_imm_ctrl: RTL and testbench

Decode-stage immediate controller for the pipelined RV32I core.
- Accepts instructions from IF/ID over a valid/ready handshake.
- Decodes opcode/funct3 into EXTOp and slices the six immediate fields.
- Drives one instance of the existing immediate extender.
- Registers {pc, imm, EXTOp, illegal} toward EX through a 2-entry skid buffer, with flush for branch/jump redirects.

---
 rtl/id_imm_ctrl_pkg.sv | 72 +++++++
 rtl/id_imm_ctrl_ext.sv | 37 +++
 rtl/id_imm_ctrl.sv | 115 +++++++++++
 tb/tb_id_imm_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/id_imm_ctrl_pkg.sv
// Shared decode constants, entry payload and decode helper for the
// decode-stage immediate controller.
//   DATA_W        : pc / immediate width (RV32I only)
//   EXT_CTRL_*    : one-hot EXTOp codes consumed by the immediate extender
//   OPC_*         : RV32I major opcodes
//   entry_t       : {pc, imm, extop, illegal} payload carried toward EX
//   decode()      : opcode/funct3 -> {extop, illegal}
package id_imm_ctrl_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned EXTOP_W = 6;
  localparam int unsigned OPC_W   = 7;

  localparam logic [EXTOP_W-1:0] EXT_CTRL_ITYPE_SHAMT = 6'b100000;
  localparam logic [EXTOP_W-1:0] EXT_CTRL_ITYPE       = 6'b010000;
  localparam logic [EXTOP_W-1:0] EXT_CTRL_STYPE       = 6'b001000;
  localparam logic [EXTOP_W-1:0] EXT_CTRL_BTYPE       = 6'b000100;
  localparam logic [EXTOP_W-1:0] EXT_CTRL_UTYPE       = 6'b000010;
  localparam logic [EXTOP_W-1:0] EXT_CTRL_JTYPE       = 6'b000001;
  localparam logic [EXTOP_W-1:0] EXT_CTRL_NONE        = 6'b000000;

  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  typedef struct packed {
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  imm;
    logic [EXTOP_W-1:0] extop;
    logic               illegal;
  } entry_t;

  typedef struct packed {
    logic [EXTOP_W-1:0] extop;
    logic               illegal;
  } dec_t;

  // Opcode/funct3 classification; R-type, FENCE and SYSTEM carry no immediate.
  function automatic dec_t decode(input logic [DATA_W-1:0] instr);
    dec_t d;
    d.extop   = EXT_CTRL_NONE;
    d.illegal = 1'b0;
    case (instr[6:0])
      OPC_OPIMM: begin
        if (instr[14:12] == F3_SLLI || instr[14:12] == F3_SRXI)
          d.extop = EXT_CTRL_ITYPE_SHAMT;
        else
          d.extop = EXT_CTRL_ITYPE;
      end
      OPC_LOAD, OPC_JALR:            d.extop = EXT_CTRL_ITYPE;
      OPC_STORE:                     d.extop = EXT_CTRL_STYPE;
      OPC_BRANCH:                    d.extop = EXT_CTRL_BTYPE;
      OPC_LUI, OPC_AUIPC:            d.extop = EXT_CTRL_UTYPE;
      OPC_JAL:                       d.extop = EXT_CTRL_JTYPE;
      OPC_OP, OPC_FENCE, OPC_SYSTEM: d.extop = EXT_CTRL_NONE;
      default:                       d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_imm_ctrl_ext.sv
// Immediate extender: selects and sign/zero-extends one of the sliced
// immediate fields according to a one-hot EXTOp.
//   i_iimm_shamt : shift amount (zero-extended)
//   i_iimm       : I-type imm[11:0]
//   i_simm       : S-type imm[11:0]
//   i_bimm       : B-type imm[12:1]
//   i_uimm       : U-type imm[31:12]
//   i_jimm       : J-type imm[20:1]
//   i_extop      : one-hot select
//   o_immout     : 32-bit immediate (0 when no select bit is set)
module id_imm_ctrl_ext
  import id_imm_ctrl_pkg::*;
(
  input  logic [4:0]         i_iimm_shamt,
  input  logic [11:0]        i_iimm,
  input  logic [11:0]        i_simm,
  input  logic [11:0]        i_bimm,
  input  logic [19:0]        i_uimm,
  input  logic [19:0]        i_jimm,
  input  logic [EXTOP_W-1:0] i_extop,
  output logic [DATA_W-1:0]  o_immout
);

  always_comb begin
    o_immout = '0;
    case (i_extop)
      EXT_CTRL_ITYPE_SHAMT: o_immout = {27'b0, i_iimm_shamt};
      EXT_CTRL_ITYPE:       o_immout = {{20{i_iimm[11]}}, i_iimm};
      EXT_CTRL_STYPE:       o_immout = {{20{i_simm[11]}}, i_simm};
      EXT_CTRL_BTYPE:       o_immout = {{19{i_bimm[11]}}, i_bimm, 1'b0};
      EXT_CTRL_UTYPE:       o_immout = {i_uimm, 12'b0};
      EXT_CTRL_JTYPE:       o_immout = {{11{i_jimm[19]}}, i_jimm, 1'b0};
      default:              o_immout = '0;
    endcase
  end

endmodule

// File: rtl/id_imm_ctrl.sv
// Decode-stage immediate controller: decodes EXTOp, extends the immediate
// and registers {pc, imm, extop, illegal} toward EX through a 2-entry skid
// buffer (output register + skid register) with flush on redirect.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : IF/ID handshake (in_ready purely registered)
//   in_instr, in_pc          : instruction word and its PC
//   flush                    : drop both entries and any same-cycle input
//   out_valid/out_ready      : EX handshake
//   out_pc/imm/extop/illegal : output entry payload
module id_imm_ctrl
  import id_imm_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [XLEN-1:0]     in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [XLEN-1:0]     out_imm,
  output logic [EXTOP_W-1:0]  out_extop,
  output logic                out_illegal
);

  dec_t        w_dec;
  logic [31:0] w_imm;
  entry_t      w_new;
  logic        w_accept;
  logic        w_consume;

  entry_t r_out,       w_out_n;
  entry_t r_skid,      w_skid_n;
  logic   r_out_valid, w_out_valid_n;
  logic   r_skid_valid, w_skid_valid_n;
  logic   r_in_ready;

  assign w_dec = decode(in_instr);

  id_imm_ctrl_ext u_ext (
    .i_iimm_shamt (in_instr[24:20]),
    .i_iimm       (in_instr[31:20]),
    .i_simm       ({in_instr[31:25], in_instr[11:7]}),
    .i_bimm       ({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]}),
    .i_uimm       (in_instr[31:12]),
    .i_jimm       ({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21]}),
    .i_extop      (w_dec.extop),
    .o_immout     (w_imm)
  );

  // Incoming entry; illegal words are forced to a zero immediate.
  always_comb begin
    w_new.pc      = DATA_W'(in_pc);
    w_new.imm     = w_dec.illegal ? '0 : w_imm;
    w_new.extop   = w_dec.extop;
    w_new.illegal = w_dec.illegal;
  end

  // A flushed input is never accepted even if in_ready is high.
  assign w_accept  = in_valid & r_in_ready & ~flush;
  assign w_consume = r_out_valid & out_ready;

  // Skid next-state: the skid entry drains into the output ahead of new input.
  always_comb begin
    w_out_n        = r_out;
    w_out_valid_n  = r_out_valid;
    w_skid_n       = r_skid;
    w_skid_valid_n = r_skid_valid;
    if (flush) begin
      w_out_valid_n  = 1'b0;
      w_skid_valid_n = 1'b0;
    end else if (!r_out_valid || w_consume) begin
      if (r_skid_valid) begin
        // in_ready was low, so no input competes with the skid entry
        w_out_n        = r_skid;
        w_out_valid_n  = 1'b1;
        w_skid_valid_n = 1'b0;
      end else begin
        w_out_valid_n = w_accept;
        if (w_accept) w_out_n = w_new;
      end
    end else if (w_accept) begin
      w_skid_n       = w_new;
      w_skid_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_out        <= w_out_n;
      r_out_valid  <= w_out_valid_n;
      r_skid       <= w_skid_n;
      r_skid_valid <= w_skid_valid_n;
      r_in_ready   <= ~w_skid_valid_n;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_pc      = XLEN'(r_out.pc);
  assign out_imm     = XLEN'(r_out.imm);
  assign out_extop   = r_out.extop;
  assign out_illegal = r_out.illegal;

endmodule

// File: tb/tb_id_imm_ctrl.sv
module tb_id_imm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [5:0]  out_extop;
  logic        out_illegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_imm_ctrl #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_imm     (out_imm),
    .out_extop   (out_extop),
    .out_illegal (out_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [5:0]  extop;
    logic        ill;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] imm,
                           input logic [5:0] extop, input logic ill);
    check({tag, ".valid"},   32'(out_valid),   32'd1);
    check({tag, ".pc"},      out_pc,           pc);
    check({tag, ".imm"},     out_imm,          imm);
    check({tag, ".extop"},   32'(out_extop),   32'(extop));
    check({tag, ".illegal"}, 32'(out_illegal), 32'(ill));
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_instr = 32'h0;
    in_pc    = 32'h0;
    flush    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'h100, 32'hFFFFFFFF, 6'b010000, 1'b0}; // addi x1,x0,-1
    vecs[1]  = '{32'h4030D093, 32'h104, 32'h00000003, 6'b100000, 1'b0}; // srai x1,x1,3
    vecs[2]  = '{32'hFE000EE3, 32'h108, 32'hFFFFFFFC, 6'b000100, 1'b0}; // beq x0,x0,-4
    vecs[3]  = '{32'h123450B7, 32'h10C, 32'h12345000, 6'b000010, 1'b0}; // lui x1,0x12345
    vecs[4]  = '{32'h0000007F, 32'h110, 32'h00000000, 6'b000000, 1'b1}; // illegal opcode
    vecs[5]  = '{32'h003100B3, 32'h114, 32'h00000000, 6'b000000, 1'b0}; // add x1,x2,x3
    vecs[6]  = '{32'h0020A423, 32'h118, 32'h00000008, 6'b001000, 1'b0}; // sw x2,8(x1)
    vecs[7]  = '{32'hFF9FF0EF, 32'h11C, 32'hFFFFFFF8, 6'b000001, 1'b0}; // jal x1,-8
    vecs[8]  = '{32'h00001097, 32'h120, 32'h00001000, 6'b000010, 1'b0}; // auipc x1,1
    vecs[9]  = '{32'hFFC12083, 32'h124, 32'hFFFFFFFC, 6'b010000, 1'b0}; // lw x1,-4(x2)
    vecs[10] = '{32'h01F09093, 32'h128, 32'h0000001F, 6'b100000, 1'b0}; // slli x1,x1,31
    vecs[11] = '{32'h0FF0000F, 32'h12C, 32'h00000000, 6'b000000, 1'b0}; // fence
    vecs[12] = '{32'h00000073, 32'h130, 32'h00000000, 6'b000000, 1'b0}; // ecall
    vecs[13] = '{32'h00008067, 32'h134, 32'h00000000, 6'b010000, 1'b0}; // jalr x0,0(x1)
    vecs[14] = '{32'h1234565B, 32'h138, 32'h00000000, 6'b000000, 1'b1}; // illegal opcode

    // Reset
    idle_inputs();
    out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_pc",    out_pc,         32'd0);
    check("reset.out_imm",   out_imm,        32'd0);
    check("reset.out_extop", 32'(out_extop), 32'd0);
    check("reset.illegal",   32'(out_illegal), 32'd0);
    check("reset.in_ready",  32'(in_ready),  32'd1);

    // Back-to-back stream, out_ready high: one-cycle latency, full throughput
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = vecs[i].pc;
      @(negedge clk);
      check_out($sformatf("vec%0d", i), vecs[i].pc, vecs[i].imm, vecs[i].extop, vecs[i].ill);
      check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
    end
    idle_inputs();
    @(negedge clk);
    check("drain.out_valid", 32'(out_valid), 32'd0);

    // Backpressure: A accepted to output, B to skid, C refused
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = vecs[0].instr; in_pc = 32'h200;   // A
    @(negedge clk);
    check("bp.A.in_ready", 32'(in_ready), 32'd1);
    in_instr = vecs[3].instr; in_pc = 32'h204;                    // B
    @(negedge clk);
    check("bp.full.in_ready", 32'(in_ready), 32'd0);
    in_instr = vecs[2].instr; in_pc = 32'h208;                    // C
    for (int k = 0; k < 3; k++) begin
      check_out($sformatf("bp.stall%0d", k), 32'h200, 32'hFFFFFFFF, 6'b010000, 1'b0);
      check($sformatf("bp.stall%0d.in_ready", k), 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_out("bp.B", 32'h204, 32'h12345000, 6'b000010, 1'b0);
    check("bp.B.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check_out("bp.C", 32'h208, 32'hFFFFFFFC, 6'b000100, 1'b0);
    idle_inputs();
    @(negedge clk);
    check("bp.empty", 32'(out_valid), 32'd0);

    // Flush while full, with a same-cycle input that must be discarded
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = vecs[1].instr; in_pc = 32'h300;
    @(negedge clk);
    in_pc = 32'h304;
    @(negedge clk);
    check("fl.full.in_ready", 32'(in_ready), 32'd0);
    check("fl.full.out_pc",   out_pc,        32'h300);
    out_ready = 1'b1;
    flush = 1'b1; in_valid = 1'b1; in_instr = vecs[9].instr; in_pc = 32'h308;
    @(negedge clk);
    idle_inputs();
    check("fl.out_valid", 32'(out_valid), 32'd0);
    check("fl.in_ready",  32'(in_ready),  32'd1);
    repeat (2) begin
      @(negedge clk);
      check("fl.no_ghost", 32'(out_valid), 32'd0);
    end

    // Flush with in_ready high and an empty buffer: input still discarded
    flush = 1'b1; in_valid = 1'b1; in_instr = vecs[0].instr; in_pc = 32'h400;
    @(negedge clk);
    idle_inputs();
    check("fl2.out_valid", 32'(out_valid), 32'd0);

    // Reset overrides a full buffer and a simultaneous handshake
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = vecs[7].instr; in_pc = 32'h500;
    @(negedge clk);
    in_pc = 32'h504;
    @(negedge clk);
    rst = 1'b1; in_pc = 32'h508; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    check("rst2.out_valid", 32'(out_valid), 32'd0);
    check("rst2.out_pc",    out_pc,         32'd0);
    check("rst2.out_imm",   out_imm,        32'd0);
    check("rst2.in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    check("rst2.no_ghost",  32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
